// File: rtl/itr_ctrl.sv
// Interrupt controller: synchronises and edge-detects NSRC sources, keeps a masked pending set,
// and hands the core one itr pulse per grant, re-arming only after EOI plus a hold-off interval.
module itr_ctrl #(
  parameter int NSRC    = 4,
  parameter int HOLDOFF = 4,
  parameter int NBHOLD  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            cfg_wr,
  input  logic [1:0]      cfg_addr,
  input  logic [NSRC-1:0] cfg_data,
  input  logic [1:0]      rd_addr,
  output logic [NSRC-1:0] rd_data,
  output logic            itr,
  output logic            busy
);

  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [NBHOLD-1:0] HOLD_LOAD = (HOLDOFF > 0) ? NBHOLD'(HOLDOFF - 1) : '0;
  localparam logic [NSRC-1:0]   SRC_ONE   = NSRC'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NSRC-1:0]    s1_q, s2_q, s3_q;
  logic [NSRC-1:0]    mask_q, mask_d;
  logic [NSRC-1:0]    pending_q, pending_d;
  logic [IDW-1:0]     active_id_q, active_id_d;
  logic [NBHOLD-1:0]  hold_q, hold_d;
  logic               itr_q, itr_d;

  logic [NSRC-1:0]    rise_s, req_s, grant_s, set_s, clr_s;
  logic [IDW-1:0]     win_s;
  logic               wr_mask_s, wr_eoi_s, wr_set_s, wr_clr_s;

  assign wr_mask_s = cfg_wr && (cfg_addr == 2'd0);
  assign wr_eoi_s  = cfg_wr && (cfg_addr == 2'd1);
  assign wr_set_s  = cfg_wr && (cfg_addr == 2'd2);
  assign wr_clr_s  = cfg_wr && (cfg_addr == 2'd3);

  // s3 clears on reset, so a source already high at release still yields one rise
  assign rise_s = s2_q & ~s3_q;
  assign req_s  = pending_q & mask_q;

  // Lowest set index wins: scan downwards so the last hit is the smallest index
  always_comb begin
    win_s = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      win_s = req_s[i] ? IDW'(i) : win_s;
    end
  end

  // Sets beat clears when both hit the same bit in one cycle
  assign set_s     = rise_s | (wr_set_s ? cfg_data : '0);
  assign clr_s     = grant_s | (wr_clr_s ? cfg_data : '0);
  assign pending_d = set_s | (pending_q & ~clr_s);
  assign mask_d    = wr_mask_s ? cfg_data : mask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req_s) state_d = ST_REQ; else state_d = ST_IDLE;
      ST_REQ:     state_d = ST_SERVICE;
      ST_SERVICE: if (wr_eoi_s) state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
                  else state_d = ST_SERVICE;
      ST_HOLD:    if (hold_q == '0) state_d = ST_IDLE; else state_d = ST_HOLD;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    itr_d       = 1'b0;
    grant_s     = '0;
    active_id_d = active_id_q;
    hold_d      = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_s) begin
          itr_d       = 1'b1;
          grant_s     = SRC_ONE << win_s;
          active_id_d = win_s;
        end else begin
          itr_d = 1'b0;
        end
      end
      ST_SERVICE: if (wr_eoi_s) hold_d = HOLD_LOAD; else hold_d = hold_q;
      ST_HOLD:    if (hold_q != '0) hold_d = hold_q - NBHOLD'(1); else hold_d = hold_q;
      default:    itr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      active_id_q <= '0;
      hold_q      <= '0;
      itr_q       <= 1'b0;
    end else begin
      s1_q        <= src;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      hold_q      <= hold_d;
      itr_q       <= itr_d;
    end
  end

  assign itr  = itr_q;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = mask_q;
      2'd1:    rd_data = pending_q;
      2'd2:    rd_data[IDW-1:0] = active_id_q;
      2'd3:    rd_data[0] = busy;
      default: rd_data = '0;
    endcase
  end

endmodule
